// File: rtl/impact_pkg.sv
// ============================================================================
// Module   : impact_pkg
// Purpose  : Shared widths, default timing and FSM state type for the
//            IMPACT SRAM GPIO sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package impact_pkg;

  localparam int WORD_W = 10;
  localparam int BANK_W = 2;
  localparam int BYTE_W = 2;
  localparam int DATA_W = 32;

  localparam int PRE_CYCLES_DEF = 2;
  localparam int WE_CYCLES_DEF  = 2;
  localparam int RD_SETTLE_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PRE    = 3'd3,
    ST_WRITE  = 3'd4,
    ST_RDEN   = 3'd5,
    ST_RDBYTE = 3'd6,
    ST_RESP   = 3'd7
  } seq_state_t;

  function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] w,
                                          input logic [BYTE_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = w >> {b, 3'b000};
    return s[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/impact_seq_timer.sv
// ============================================================================
// Module   : impact_seq_timer
// Purpose  : 4-bit load/decrement counter; o_done is high once it reaches 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module impact_seq_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/impact_sram_sequencer.sv
// ============================================================================
// Module   : impact_sram_sequencer
// Purpose  : Serialises 32-bit word requests onto the IMPACT SRAM GPIO pins.
//            Optional IMPACT_SEQ_VERIFY_EN adds a read-back check after writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module impact_sram_sequencer
  import impact_pkg::*;
#(
  parameter int PRE_CYCLES = PRE_CYCLES_DEF,
  parameter int WE_CYCLES  = WE_CYCLES_DEF,
  parameter int RD_SETTLE  = RD_SETTLE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [BANK_W-1:0] i_req_bank,
  input  logic [WORD_W-1:0] i_req_word,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [7:0]        o_sram_data_in,
  input  logic [7:0]        i_sram_data_out,
  output logic [WORD_W-1:0] o_sram_word_sel,
  output logic [BANK_W-1:0] o_sram_bank_sel,
  output logic [BYTE_W-1:0] o_sram_byte_sel,
  output logic              o_sram_we,
  output logic              o_sram_re,
  output logic              o_sram_pre
);

  seq_state_t        r_state, w_state_nxt;
  logic [BYTE_W-1:0] r_byte, w_byte_nxt;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata, r_rdata, w_rdata_cap;
  logic [WORD_W-1:0] r_word_sel;
  logic [BANK_W-1:0] r_bank_sel;
  logic [7:0]        r_data_in;
  logic              r_we, r_re, r_pre, r_rsp_valid, r_req_ready;
  logic              w_tmr_load, w_tmr_done, w_capture, w_accept, w_pre_to_write;
  logic [3:0]        w_tmr_val;
`ifdef IMPACT_SEQ_VERIFY_EN
  logic              r_err, r_vphase;
`endif

  impact_seq_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_done (w_tmr_done)
  );

  assign w_accept = (r_state == ST_IDLE) && i_req_valid;

  // Once the write pulse has been issued in verify builds, PRE leads to the read path.
`ifdef IMPACT_SEQ_VERIFY_EN
  assign w_pre_to_write = r_write && !r_vphase;
`else
  assign w_pre_to_write = r_write;
`endif

  always_comb begin
    w_rdata_cap = r_rdata;
    case (r_byte)
      2'd0:    w_rdata_cap[7:0]   = i_sram_data_out;
      2'd1:    w_rdata_cap[15:8]  = i_sram_data_out;
      2'd2:    w_rdata_cap[23:16] = i_sram_data_out;
      default: w_rdata_cap[31:24] = i_sram_data_out;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_byte_nxt  = r_byte;
    w_tmr_load  = 1'b0;
    w_tmr_val   = 4'd0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: if (i_req_valid) w_state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (r_write) begin
          w_state_nxt = ST_LOAD;
          w_byte_nxt  = 2'd0;
        end else begin
          w_state_nxt = ST_PRE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = 4'(PRE_CYCLES - 1);
        end
      end
      ST_LOAD: begin
        if (r_byte == 2'd3) begin
          w_state_nxt = ST_PRE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = 4'(PRE_CYCLES - 1);
        end else begin
          w_byte_nxt = r_byte + 2'd1;
        end
      end
      ST_PRE: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          if (w_pre_to_write) begin
            w_state_nxt = ST_WRITE;
            w_tmr_val   = 4'(WE_CYCLES - 1);
          end else begin
            w_state_nxt = ST_RDEN;
            w_byte_nxt  = 2'd0;
            w_tmr_val   = 4'(RD_SETTLE - 1);
          end
        end
      end
      ST_WRITE: begin
        if (w_tmr_done) begin
`ifdef IMPACT_SEQ_VERIFY_EN
          w_state_nxt = ST_PRE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = 4'(PRE_CYCLES - 1);
`else
          w_state_nxt = ST_RESP;
`endif
        end
      end
      ST_RDEN, ST_RDBYTE: begin
        if (w_tmr_done) begin
          w_capture = 1'b1;
          if (r_byte == 2'd3) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_RDBYTE;
            w_byte_nxt  = r_byte + 2'd1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = 4'(RD_SETTLE - 1);
          end
        end
      end
      ST_RESP: if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pin registers are loaded from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_byte      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_word_sel  <= '0;
      r_bank_sel  <= '0;
      r_data_in   <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_pre       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_req_ready <= 1'b1;
`ifdef IMPACT_SEQ_VERIFY_EN
      r_err       <= 1'b0;
      r_vphase    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_byte      <= w_byte_nxt;
      r_we        <= (w_state_nxt == ST_WRITE);
      r_pre       <= (w_state_nxt == ST_PRE);
      r_re        <= (w_state_nxt == ST_RDEN) || (w_state_nxt == ST_RDBYTE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_req_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_write    <= i_req_write;
        r_wdata    <= i_req_wdata;
        r_word_sel <= i_req_word;
        r_bank_sel <= i_req_bank;
        r_rdata    <= '0;
`ifdef IMPACT_SEQ_VERIFY_EN
        r_err      <= 1'b0;
        r_vphase   <= 1'b0;
`endif
      end
      if (w_state_nxt == ST_LOAD) r_data_in <= get_byte(r_wdata, w_byte_nxt);
      if (w_capture) r_rdata <= w_rdata_cap;
`ifdef IMPACT_SEQ_VERIFY_EN
      if (r_state == ST_WRITE && w_tmr_done) r_vphase <= 1'b1;
      if (w_capture && r_byte == 2'd3) r_err <= r_write && (w_rdata_cap != r_wdata);
`endif
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_rdata     = r_rdata;
`ifdef IMPACT_SEQ_VERIFY_EN
  assign o_rsp_err       = r_err;
`else
  assign o_rsp_err       = 1'b0;
`endif
  assign o_sram_data_in  = r_data_in;
  assign o_sram_word_sel = r_word_sel;
  assign o_sram_bank_sel = r_bank_sel;
  assign o_sram_byte_sel = r_byte;
  assign o_sram_we       = r_we;
  assign o_sram_re       = r_re;
  assign o_sram_pre      = r_pre;

endmodule

`default_nettype wire

// File: tb/tb_impact_sram_sequencer.sv
// ============================================================================
// Module   : tb_impact_sram_sequencer
// Purpose  : Randomised bench for impact_sram_sequencer with an SRAM pin model
//            and a word-level shadow memory as reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_impact_sram_sequencer;

  localparam int PRE = 2;
  localparam int WE  = 2;
  localparam int RDS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_write, i_rsp_ready;
  logic [1:0]  i_req_bank;
  logic [9:0]  i_req_word;
  logic [31:0] i_req_wdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic [7:0]  o_sram_data_in, sram_dout;
  logic [9:0]  o_sram_word_sel;
  logic [1:0]  o_sram_bank_sel, o_sram_byte_sel;
  logic        o_sram_we, o_sram_re, o_sram_pre;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem    [0:4095];
  logic [31:0] shadow [0:4095];
  logic [31:0] latch;
  bit          flip_en = 1'b0;
  int          written[$];

  impact_sram_sequencer #(.PRE_CYCLES(PRE), .WE_CYCLES(WE), .RD_SETTLE(RDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_bank(i_req_bank), .i_req_word(i_req_word), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_sram_data_in(o_sram_data_in), .i_sram_data_out(sram_dout),
    .o_sram_word_sel(o_sram_word_sel), .o_sram_bank_sel(o_sram_bank_sel),
    .o_sram_byte_sel(o_sram_byte_sel), .o_sram_we(o_sram_we), .o_sram_re(o_sram_re),
    .o_sram_pre(o_sram_pre)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int b);
    logic [31:0] s;
    s = w >> (8 * b);
    return s[7:0];
  endfunction

  // SRAM head model: byte latch, write on WriteEnable, registered read mux.
  always @(posedge clk) begin
    case (o_sram_byte_sel)
      2'd0: latch[7:0]   <= o_sram_data_in;
      2'd1: latch[15:8]  <= o_sram_data_in;
      2'd2: latch[23:16] <= o_sram_data_in;
      default: latch[31:24] <= o_sram_data_in;
    endcase
    if (o_sram_we)
      mem[{o_sram_bank_sel, o_sram_word_sel}] <= (flip_en && latch == 32'd1) ? (latch ^ 32'd1) : latch;
    sram_dout <= byte_of(mem[{o_sram_bank_sel, o_sram_word_sel}], int'(o_sram_byte_sel));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input bit wr, input logic [1:0] bank, input logic [9:0] word,
                        input logic [31:0] wd, input int bp,
                        input logic [31:0] exp_rd, input logic exp_err);
    int exp_lat, exp_pre, exp_we, exp_re, lat, pre_n, we_n, re_n, excl_bad, stable_bad, w;
    logic [31:0] dseq;
    logic [7:0]  bseq;
    lat = 0; pre_n = 0; we_n = 0; re_n = 0; excl_bad = 0; stable_bad = 0; w = 0;
    dseq = '0; bseq = '0;
    exp_pre = PRE; exp_we = wr ? WE : 0; exp_re = wr ? 0 : 4 * RDS;
    exp_lat = wr ? (1 + 4 + PRE + WE) : (1 + PRE + 4 * RDS);
`ifdef IMPACT_SEQ_VERIFY_EN
    if (wr) begin
      exp_lat = exp_lat + PRE + 4 * RDS;
      exp_pre = 2 * PRE;
      exp_re  = 4 * RDS;
    end
`endif
    @(negedge clk);
    i_req_valid = 1'b1; i_req_write = wr; i_req_bank = bank; i_req_word = word;
    i_req_wdata = wd; i_rsp_ready = 1'b0;
    while (!o_req_ready && w < 20) begin @(negedge clk); w++; end
    chk("req_ready_idle", o_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (o_rsp_valid) begin lat = k; break; end
      pre_n += int'(o_sram_pre); we_n += int'(o_sram_we); re_n += int'(o_sram_re);
      if (int'(o_sram_pre) + int'(o_sram_we) + int'(o_sram_re) > 1) excl_bad++;
      if (k <= 4) begin
        dseq[8*(k-1) +: 8] = o_sram_data_in;
        bseq[2*(k-1) +: 2] = o_sram_byte_sel;
      end
    end
    chk("latency", lat, exp_lat);
    if (lat == 0) return;
    chk("pre_cycles", pre_n, exp_pre);
    chk("we_cycles", we_n, exp_we);
    chk("re_cycles", re_n, exp_re);
    chk("strobe_excl", excl_bad, 0);
    if (wr) begin
      chk("data_in_seq", dseq, wd);
      chk("byte_sel_seq", {24'd0, bseq}, 32'h0000_00E4);
    end
    chk("rsp_rdata", o_rsp_rdata, exp_rd);
    chk("rsp_err", o_rsp_err, exp_err);
    chk("busy_ready", o_req_ready, 0);
    // A competing request is presented while the response is stalled.
    i_req_valid = 1'b1; i_req_word = word ^ 10'h155;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== exp_rd || o_req_ready !== 1'b0) stable_bad++;
    end
    chk("bp_stable", stable_bad, 0);
    i_req_valid = 1'b0; i_rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_drop", o_rsp_valid, 0);
    chk("ready_back", o_req_ready, 1);
    chk("idle_strobes", {o_sram_pre, o_sram_we, o_sram_re}, 0);
    i_rsp_ready = 1'b0;
  endtask

  task automatic issue(input bit wr, input logic [1:0] bank, input logic [9:0] word,
                       input logic [31:0] wd, input int bp);
    int a;
    a = int'({bank, word});
    if (wr) begin
`ifdef IMPACT_SEQ_VERIFY_EN
      do_txn(1'b1, bank, word, wd, bp, wd, 1'b0);
`else
      do_txn(1'b1, bank, word, wd, bp, 32'd0, 1'b0);
`endif
      shadow[a] = wd;
      written.push_back(a);
    end else begin
      do_txn(1'b0, bank, word, 32'd0, bp, shadow[a], 1'b0);
    end
  endtask

  initial begin
    int a, bad;
    rst_n = 1'b0; i_req_valid = 1'b0; i_req_write = 1'b0; i_req_bank = '0;
    i_req_word = '0; i_req_wdata = '0; i_rsp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom; shadow[i] = mem[i];
    end
    mem[{2'd0, 10'h3FF}] = 32'h4433_2211; shadow[{2'd0, 10'h3FF}] = 32'h4433_2211;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pins", {o_sram_data_in, o_sram_word_sel, o_sram_bank_sel, o_sram_byte_sel,
                     o_sram_we, o_sram_re, o_sram_pre}, 0);
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp", {o_rsp_err, o_rsp_rdata[30:0]}, 0);
    rst_n = 1'b1;

    issue(1'b1, 2'd1, 10'h155, 32'hA5C3_0F81, 0);
    chk("wr_word_sel", o_sram_word_sel, 10'h155);
    chk("wr_bank_sel", o_sram_bank_sel, 2'd1);
    issue(1'b0, 2'd0, 10'h3FF, 32'd0, 5);
    issue(1'b0, 2'd1, 10'h155, 32'd0, 2);

    // Reset in the middle of the write pulse.
    @(negedge clk);
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_bank = 2'd2; i_req_word = 10'h0AA;
    i_req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("we_before_rst", o_sram_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we_async", o_sram_we, 0);
    chk("rst_strobes_async", {o_sram_pre, o_sram_re, o_rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (15) begin @(negedge clk); if (o_rsp_valid) bad++; end
    chk("no_rsp_after_rst", bad, 0);
    issue(1'b0, 2'd2, 10'h0AA, 32'd0, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1 || written.size() == 0) begin
        issue(1'b1, 2'($urandom), 10'($urandom), $urandom, $urandom_range(0, 3));
      end else begin
        if ($urandom_range(0, 1) == 1) a = written[$urandom_range(0, written.size() - 1)];
        else a = int'($urandom_range(0, 4095));
        issue(1'b0, 2'(a >> 10), 10'(a), 32'd0, $urandom_range(0, 3));
      end
    end

`ifdef IMPACT_SEQ_VERIFY_EN
    flip_en = 1'b1;
    do_txn(1'b1, 2'd3, 10'h001, 32'h0000_0001, 0, 32'h0000_0000, 1'b1);
    flip_en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
